dot_product_sequencer: RTL and testbench

Front-end controller that drives the 8-bit signed multiply-accumulate unit's `a`/`b`/`valid_in` input stream and consumes its `f`/`valid_out` result stream. It holds two operand vectors in a local register file, clears the MAC, issues one element pair per cycle, and counts returned `valid_out` pulses. It then hands the 16-bit dot product to the downstream layer logic over a valid/ready handshake.

---
 rtl/dps_pkg.sv | 16 +
 rtl/dps_vec_regfile.sv | 35 +++
 rtl/dot_product_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dps_pkg.sv
// Shared types and widths for the dot-product sequencer.
package dps_pkg;

    localparam int unsigned OP_W        = 8;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } dps_state_t;

endpackage

// File: rtl/dps_vec_regfile.sv
// Operand store: banks A and B, one write port, one shared combinational read index.
module dps_vec_regfile
    import dps_pkg::*;
#(
    parameter int unsigned VEC_LEN_MAX = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [OP_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [OP_W-1:0]   o_rd_a,
    output logic [OP_W-1:0]   o_rd_b
);

    logic [OP_W-1:0] r_bank_a [VEC_LEN_MAX];
    logic [OP_W-1:0] r_bank_b [VEC_LEN_MAX];

    // Element write into the selected bank; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_sel) begin
                r_bank_b[i_wr_addr] <= i_wr_data;
            end else begin
                r_bank_a[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_rd_a = r_bank_a[i_rd_idx];
    assign o_rd_b = r_bank_b[i_rd_idx];

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences an operand pair stream into an external MAC and returns the dot product.
module dot_product_sequencer
    import dps_pkg::*;
#(
    parameter int unsigned VEC_LEN_MAX = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]   wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              mac_clear,
    output logic [OP_W-1:0]   mac_a,
    output logic [OP_W-1:0]   mac_b,
    output logic              mac_valid_in,
    input  logic [ACC_W-1:0]  mac_f,
    input  logic              mac_valid_out,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              err
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    dps_state_t        r_state;
    dps_state_t        w_next_state;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_rcount;
    logic [TO_W-1:0]   r_tcnt;
    logic              r_clear_cnt;
    logic              r_clear;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [OP_W-1:0]   w_rd_a;
    logic [OP_W-1:0]   w_rd_b;
    logic              w_len_over;
    logic              w_len_bad;
    logic              w_last_issue;
    logic              w_done;
    logic              w_timeout;
    logic              w_capture;
    logic [ACC_W-1:0]  w_result_nxt;
    logic              w_err_nxt;

    assign w_len_over   = (len > LEN_W'(VEC_LEN_MAX));
    assign w_len_bad    = (len == '0) || w_len_over;
    assign w_last_issue = (r_idx == r_len_q - LEN_W'(1));
    assign w_done       = mac_valid_out && (LEN_W'(r_rcount + LEN_W'(1)) == r_len_q);
    assign w_timeout    = (r_tcnt == TO_W'(TIMEOUT - 1));
    // Prefetch the element that the next ISSUE cycle presents
    assign w_rd_idx     = (r_state == S_ISSUE) ? ADDR_W'(r_idx + LEN_W'(1)) : '0;
    assign mac_clear    = reset | r_clear;

    dps_vec_regfile #(
        .VEC_LEN_MAX (VEC_LEN_MAX),
        .ADDR_W      (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .i_wr_en   (wr_en && (r_state == S_IDLE)),
        .i_wr_sel  (wr_sel),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_a    (w_rd_a),
        .o_rd_b    (w_rd_b)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and result capture decisions
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_result_nxt = '0;
        w_err_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_bad) begin
                        w_next_state = S_HOLD;
                        w_capture    = 1'b1;
                        w_err_nxt    = w_len_over;
                    end else begin
                        w_next_state = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (r_clear_cnt) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_issue) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_next_state = S_HOLD;
                    w_capture    = 1'b1;
                    w_result_nxt = mac_f;
                end else if (w_timeout) begin
                    w_next_state = S_HOLD;
                    w_capture    = 1'b1;
                    w_result_nxt = mac_f;
                    w_err_nxt    = 1'b1;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            r_clear      <= 1'b0;
            mac_valid_in <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            err          <= 1'b0;
        end else begin
            busy         <= (w_next_state != S_IDLE);
            r_clear      <= (w_next_state == S_CLEAR);
            mac_valid_in <= (w_next_state == S_ISSUE);
            result_valid <= (w_next_state == S_HOLD);
            if (w_next_state == S_ISSUE) begin
                mac_a <= w_rd_a;
                mac_b <= w_rd_b;
            end
            if (w_capture) begin
                result <= w_result_nxt;
                err    <= w_err_nxt;
            end
        end
    end

    // Length latch plus clear, issue, return and timeout counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_q     <= '0;
            r_clear_cnt <= 1'b0;
            r_idx       <= '0;
            r_rcount    <= '0;
            r_tcnt      <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_len_q <= len;
            end
            r_clear_cnt <= (r_state == S_CLEAR) ? ~r_clear_cnt : 1'b0;
            r_idx       <= (r_state == S_ISSUE) ? r_idx + LEN_W'(1) : '0;
            r_tcnt      <= (r_state == S_DRAIN) ? r_tcnt + TO_W'(1) : '0;
            if (r_state == S_IDLE) begin
                r_rcount <= '0;
            end else if (((r_state == S_ISSUE) || (r_state == S_DRAIN)) && mac_valid_out) begin
                r_rcount <= r_rcount + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer with a behavioural MAC attached.
module tb_dot_product_sequencer;

    localparam int TIMEOUT = 32;
    localparam int BUDGET  = 200;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        mac_clear;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_valid_in;
    logic [15:0] mac_f;
    logic        mac_valid_out;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;
    int sa [16];
    int sb [16];
    int drop_idx = -1;

    dot_product_sequencer #(
        .VEC_LEN_MAX (16),
        .ADDR_W      (4),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .mac_clear     (mac_clear),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .result        (result),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: product register then accumulator, two-cycle latency
    logic signed [15:0] m_p;
    logic               m_pv;
    logic               m_vo;
    logic [15:0]        m_acc;
    int                 m_vo_cnt;

    always @(posedge clk) begin
        if (mac_clear) begin
            m_p      <= '0;
            m_pv     <= 1'b0;
            m_vo     <= 1'b0;
            m_acc    <= '0;
            m_vo_cnt <= 0;
        end else begin
            m_p  <= $signed(mac_a) * $signed(mac_b);
            m_pv <= mac_valid_in;
            m_vo <= m_pv;
            if (m_pv) m_acc <= m_acc + m_p;
            if (m_vo) m_vo_cnt <= m_vo_cnt + 1;
        end
    end

    assign mac_f         = m_acc;
    assign mac_valid_out = m_vo && (m_vo_cnt != drop_idx);

    // Reference: plain signed sum of products, wrapped to 16 bits
    function automatic logic [15:0] ref_dot(input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < n; i++) acc += sa[i] * sb[i];
        return 16'(acc);
    endfunction

    task automatic write_el(input logic sel, input int addr, input int val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(val);
        if (sel) sb[addr] = val; else sa[addr] = val;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts a run and observes the stream until result_valid (caller sits at a negedge)
    task automatic do_run(input int n, input logic with_wr, input logic wsel, input int waddr,
                          input int wval, output int rv_k, output int vin_cnt, output int clr_cnt,
                          output int first_clr_k, output int first_vin_k, output int last_vin_k,
                          output int pair_err);
        int k;
        len = 5'(n);
        start = 1'b1;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_sel  = wsel;
            wr_addr = 4'(waddr);
            wr_data = 8'(wval);
            if (wsel) sb[waddr] = wval; else sa[waddr] = wval;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        rv_k = -1; vin_cnt = 0; clr_cnt = 0; first_clr_k = -1; first_vin_k = -1;
        last_vin_k = -1; pair_err = 0;
        k = 1;
        while (k <= BUDGET) begin
            if (mac_clear) begin
                clr_cnt++;
                if (first_clr_k < 0) first_clr_k = k;
            end
            if (mac_valid_in) begin
                if (vin_cnt >= 16 || mac_a !== 8'(sa[vin_cnt]) || mac_b !== 8'(sb[vin_cnt]))
                    pair_err++;
                if (first_vin_k < 0) first_vin_k = k;
                last_vin_k = k;
                vin_cnt++;
            end
            if (result_valid) begin
                rv_k = k;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (mac_clear !== 1'b1) begin n_miss++; $display("FAIL reset_mac_clear: got %b expected 1", mac_clear); end
        n_vec++; if (mac_valid_in !== 1'b0 || mac_a !== 8'd0 || mac_b !== 8'd0) begin
            n_miss++; $display("FAIL reset_mac_ops: got vin=%b a=%0d b=%0d expected 0/0/0", mac_valid_in, mac_a, mac_b); end
        n_vec++; if (result_valid !== 1'b0 || err !== 1'b0 || result !== 16'd0) begin
            n_miss++; $display("FAIL reset_result: got rv=%b err=%b res=%0d expected 0/0/0", result_valid, err, result); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (mac_clear !== 1'b0) begin n_miss++; $display("FAIL post_reset_clear: got %b expected 0", mac_clear); end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) begin
            write_el(1'b0, i, i + 1);
            write_el(1'b1, i, i + 5);
        end
    endtask

    task automatic test_basic();
        int rv_k, vin, clr, fclr, fvin, lvin, perr;
        logic [15:0] exp;
        load_basic();
        exp = ref_dot(4);
        do_run(4, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k < 0) begin n_miss++; $display("FAIL basic_done: no result_valid within %0d cycles", BUDGET); end
        n_vec++; if (result !== exp || exp !== 16'd70) begin n_miss++; $display("FAIL basic_result: got %0d expected %0d", $signed(result), $signed(exp)); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL basic_err: got %b expected 0", err); end
        n_vec++; if (vin !== 4 || perr !== 0) begin n_miss++; $display("FAIL basic_issue: got %0d cycles %0d bad pairs expected 4 and 0", vin, perr); end
        n_vec++; if (clr !== 2 || fclr !== 1 || fvin !== 3) begin
            n_miss++; $display("FAIL basic_timing: got clr=%0d first_clr=%0d first_vin=%0d expected 2/1/3", clr, fclr, fvin); end
        n_vec++; if (rv_k !== lvin + 3) begin n_miss++; $display("FAIL basic_latency: got rv at %0d expected %0d", rv_k, lvin + 3); end
        accept();
        n_vec++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_miss++; $display("FAIL basic_accept: got busy=%b rv=%b expected 0/0", busy, result_valid); end
    endtask

    task automatic test_signed_extremes();
        int rv_k, vin, clr, fclr, fvin, lvin, perr;
        logic [15:0] exp;
        write_el(1'b0, 0, -128); write_el(1'b0, 1, -128);
        write_el(1'b1, 0, -128); write_el(1'b1, 1, 127);
        exp = ref_dot(2);
        do_run(2, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k < 0 || result !== exp || err !== 1'b0) begin
            n_miss++; $display("FAIL signed_result: got %0d err=%b expected %0d err=0", $signed(result), err, $signed(exp)); end
        accept();
    endtask

    task automatic test_len_boundaries();
        int rv_k, vin, clr, fclr, fvin, lvin, perr;
        logic [15:0] exp;
        do_run(0, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k !== 1 || result !== 16'd0 || err !== 1'b0) begin
            n_miss++; $display("FAIL len0_result: got rv_k=%0d res=%0d err=%b expected 1/0/0", rv_k, result, err); end
        n_vec++; if (vin !== 0 || clr !== 0) begin n_miss++; $display("FAIL len0_no_mac: got vin=%0d clr=%0d expected 0/0", vin, clr); end
        accept();
        do_run(17, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k !== 1 || result !== 16'd0 || err !== 1'b1 || vin !== 0) begin
            n_miss++; $display("FAIL len17: got rv_k=%0d res=%0d err=%b vin=%0d expected 1/0/1/0", rv_k, result, err, vin); end
        accept();
        for (int i = 0; i < 16; i++) begin
            write_el(1'b0, i, 127);
            write_el(1'b1, i, 127);
        end
        exp = ref_dot(16);
        do_run(16, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k < 0 || result !== exp || $signed(exp) !== -16'sd4080 || err !== 1'b0 || vin !== 16) begin
            n_miss++; $display("FAIL len16_wrap: got %0d err=%b vin=%0d expected %0d err=0 vin=16", $signed(result), err, vin, $signed(exp)); end
        accept();
    endtask

    task automatic test_random();
        int rv_k, vin, clr, fclr, fvin, lvin, perr, n;
        logic [15:0] exp;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin
                write_el(1'b0, i, int'($urandom_range(0, 255)) - 128);
                write_el(1'b1, i, int'($urandom_range(0, 255)) - 128);
            end
            exp = ref_dot(n);
            do_run(n, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
            n_vec++; if (rv_k < 0 || result !== exp || err !== 1'b0 || vin !== n || perr !== 0) begin
                n_miss++; $display("FAIL random_%0d: len=%0d got %0d err=%b vin=%0d badpairs=%0d expected %0d", it, n, $signed(result), err, vin, perr, $signed(exp)); end
            accept();
        end
    endtask

    task automatic test_start_with_write();
        int rv_k, vin, clr, fclr, fvin, lvin, perr;
        logic [15:0] exp;
        load_basic();
        do_run(4, 1'b1, 1'b1, 3, -9, rv_k, vin, clr, fclr, fvin, lvin, perr);
        exp = ref_dot(4);
        n_vec++; if (rv_k < 0 || result !== exp || perr !== 0) begin
            n_miss++; $display("FAIL start_write: got %0d badpairs=%0d expected %0d", $signed(result), perr, $signed(exp)); end
        accept();
    endtask

    task automatic test_backpressure();
        int rv_k, vin, clr, fclr, fvin, lvin, perr, bad;
        logic [15:0] exp;
        logic [15:0] held;
        load_basic();
        do_run(4, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        held = result;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            len = 5'd2;
            start = (c == 1);
            @(negedge clk);
            start = 1'b0;
            if (result !== held || err !== 1'b0 || result_valid !== 1'b1 || mac_clear !== 1'b0) bad++;
        end
        n_vec++; if (rv_k < 0 || bad !== 0) begin n_miss++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        accept();
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || mac_clear !== 1'b0) begin n_miss++; $display("FAIL hold_start_ignored: got busy=%b clr=%b expected 0/0", busy, mac_clear); end
        write_el(1'b0, 0, 2);
        write_el(1'b1, 0, 2);
        exp = ref_dot(1);
        result_ready = 1'b1;
        do_run(1, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k < 0 || result !== exp || exp !== 16'd4) begin n_miss++; $display("FAIL second_run: got %0d expected %0d", $signed(result), $signed(exp)); end
        @(negedge clk);
        result_ready = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL early_ready: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int rv_k, vin, clr, fclr, fvin, lvin, perr;
        logic [15:0] exp;
        load_basic();
        exp = ref_dot(4);
        drop_idx = 3;
        do_run(4, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        drop_idx = -1;
        n_vec++; if (rv_k < 0 || err !== 1'b1 || result !== exp) begin
            n_miss++; $display("FAIL timeout_err: got err=%b res=%0d expected 1 and %0d", err, $signed(result), $signed(exp)); end
        n_vec++; if (rv_k - lvin !== TIMEOUT + 1) begin
            n_miss++; $display("FAIL timeout_cycles: got %0d expected %0d", rv_k - lvin, TIMEOUT + 1); end
        accept();
    endtask

    task automatic test_mid_reset();
        int rv_k, vin, clr, fclr, fvin, lvin, perr, seen, c;
        logic [15:0] exp;
        load_basic();
        len = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        c = 0;
        while (c < 20 && seen < 2) begin
            if (mac_valid_in) seen++;
            if (seen < 2) begin
                @(negedge clk);
                c++;
            end
        end
        n_vec++; if (seen !== 2) begin n_miss++; $display("FAIL mid_reset_reach: got %0d issue cycles expected 2", seen); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || mac_valid_in !== 1'b0 || result_valid !== 1'b0 || mac_clear !== 1'b1) begin
            n_miss++; $display("FAIL mid_reset_abort: got busy=%b vin=%b rv=%b clr=%b expected 0/0/0/1", busy, mac_valid_in, result_valid, mac_clear); end
        reset = 1'b0;
        @(negedge clk);
        exp = ref_dot(4);
        do_run(4, 1'b0, 1'b0, 0, 0, rv_k, vin, clr, fclr, fvin, lvin, perr);
        n_vec++; if (rv_k < 0 || result !== exp || exp !== 16'd70 || err !== 1'b0) begin
            n_miss++; $display("FAIL mid_reset_rerun: got %0d err=%b expected %0d", $signed(result), err, $signed(exp)); end
        accept();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; result_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin sa[i] = 0; sb[i] = 0; end
        test_reset();
        test_basic();
        test_signed_extremes();
        test_len_boundaries();
        test_random();
        test_start_with_write();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
